// File: rtl/write_bus_arbiter_if.sv
// Write-bus bundle between the requesters, the arbiter and the control logic unit.
// Per-requester fields are packed side by side: requester i owns
// addr[5i+4:5i], data[8i+7:8i], req[i], clr_req[i] and ack[i].
interface write_bus_arbiter_if #(
    parameter int N_REQ = 4
);
    logic [N_REQ-1:0]   req;
    logic [5*N_REQ-1:0] addr;
    logic [8*N_REQ-1:0] data;
    logic [N_REQ-1:0]   clr_req;
    logic [N_REQ-1:0]   ack;
    logic               cs;
    logic [15:0]        data_out;
    logic [2:0]         gnt_id;
    logic               busy;

    // Requester / control-logic side: drives requests, observes arbiter outputs
    modport master (
        output req, addr, data, clr_req,
        input  ack, cs, data_out, gnt_id, busy
    );

    // Arbiter side
    modport slave (
        input  req, addr, data, clr_req,
        output ack, cs, data_out, gnt_id, busy
    );
endinterface

// File: rtl/write_bus_arbiter.sv
// Round-robin write-bus arbiter.
// One requester is granted at a time; its {clr, 2'b00, addr, data} word is
// latched onto data_out, a single-cycle cs strobe is issued, the arbiter then
// idles WAIT_CYC cycles to cover the downstream strobe delay, and finally
// pulses ack to the granted requester. The round-robin pointer moves to the
// requester after the one just served.
module write_bus_arbiter #(
    parameter int N_REQ    = 4,
    parameter int WAIT_CYC = 4
) (
    input  logic               clk_i,
    input  logic               rst_n_i,
    write_bus_arbiter_if.slave bus
);

    localparam int               CNT_W     = $clog2(WAIT_CYC + 1);
    localparam logic [CNT_W-1:0] WAIT_LOAD = CNT_W'(WAIT_CYC);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam logic [2:0]       LAST_IDX  = 3'(N_REQ - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q,   cnt_d;
    logic [2:0]        ptr_q,   ptr_d;
    logic [2:0]        gnt_q,   gnt_d;
    logic [15:0]       dout_q,  dout_d;
    logic              cs_q,    cs_d;
    logic [N_REQ-1:0]  ack_q,   ack_d;
    logic              busy_q,  busy_d;

    logic              hi_found_s;
    logic [2:0]        hi_idx_s;
    logic              any_found_s;
    logic [2:0]        lo_idx_s;
    logic              win_valid_s;
    logic [2:0]        win_idx_s;
    logic [4:0]        win_addr_s;
    logic [7:0]        win_data_s;
    logic              win_clr_s;

    // Round-robin pick: lowest requesting index at or above ptr, otherwise wrap to lowest overall
    always_comb begin
        hi_found_s  = 1'b0;
        hi_idx_s    = 3'd0;
        any_found_s = 1'b0;
        lo_idx_s    = 3'd0;
        // Descending scan so the last hit kept is the lowest index
        for (int i = N_REQ - 1; i >= 0; i--) begin
            hi_found_s  = hi_found_s | (bus.req[i] & (3'(i) >= ptr_q));
            hi_idx_s    = (bus.req[i] && (3'(i) >= ptr_q)) ? 3'(i) : hi_idx_s;
            any_found_s = any_found_s | bus.req[i];
            lo_idx_s    = bus.req[i] ? 3'(i) : lo_idx_s;
        end
        win_valid_s = any_found_s;
        win_idx_s   = hi_found_s ? hi_idx_s : lo_idx_s;
    end

    // And-or mux of the winning requester's address, payload and clear flag
    always_comb begin
        win_addr_s = 5'd0;
        win_data_s = 8'd0;
        win_clr_s  = 1'b0;
        for (int i = 0; i < N_REQ; i++) begin
            win_addr_s = win_addr_s | (bus.addr[5*i +: 5] & {5{win_idx_s == 3'(i)}});
            win_data_s = win_data_s | (bus.data[8*i +: 8] & {8{win_idx_s == 3'(i)}});
            win_clr_s  = win_clr_s  | (bus.clr_req[i] & (win_idx_s == 3'(i)));
        end
    end

    // Transaction FSM: next state and next values of all registered outputs
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        ptr_d   = ptr_q;
        gnt_d   = gnt_q;
        dout_d  = dout_q;
        cs_d    = 1'b0;
        ack_d   = {N_REQ{1'b0}};

        case (state_q)
            ST_IDLE: begin
                if (win_valid_s) begin
                    // Grant edge: word and id are frozen here until the next grant
                    state_d = ST_ISSUE;
                    gnt_d   = win_idx_s;
                    dout_d  = {win_clr_s, 2'b00, win_addr_s, win_data_s};
                    cs_d    = 1'b1;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_ISSUE: begin
                state_d = ST_WAIT;
                cnt_d   = WAIT_LOAD;
            end
            ST_WAIT: begin
                if (cnt_q <= CNT_ONE) begin
                    state_d = ST_DONE;
                    cnt_d   = {CNT_W{1'b0}};
                    for (int i = 0; i < N_REQ; i++) begin
                        ack_d[i] = (gnt_q == 3'(i));
                    end
                end else begin
                    state_d = ST_WAIT;
                    cnt_d   = cnt_q - CNT_ONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
                ptr_d   = (gnt_q == LAST_IDX) ? 3'd0 : (gnt_q + 3'd1);
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = {CNT_W{1'b0}};
            end
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    // State and output registers; reset aborts any transaction in flight
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q <= ST_IDLE;
            cnt_q   <= {CNT_W{1'b0}};
            ptr_q   <= 3'd0;
            gnt_q   <= 3'd0;
            dout_q  <= 16'h0000;
            cs_q    <= 1'b0;
            ack_q   <= {N_REQ{1'b0}};
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ptr_q   <= ptr_d;
            gnt_q   <= gnt_d;
            dout_q  <= dout_d;
            cs_q    <= cs_d;
            ack_q   <= ack_d;
            busy_q  <= busy_d;
        end
    end

    assign bus.cs       = cs_q;
    assign bus.ack      = ack_q;
    assign bus.data_out = dout_q;
    assign bus.gnt_id   = gnt_q;
    assign bus.busy     = busy_q;

endmodule

// File: doc/write_bus_arbiter.md
WRITE_BUS_ARBITER -- requirements
Module: write_bus_arbiter

Interface
REQ-001 Parameter N_REQ, default 4, number of requesters (2..8).
REQ-002 Parameter WAIT_CYC, default 4, idle cycles after each CS pulse before ACK; SHALL be >= 3 (covers downstream 3-cycle strobe delay).
REQ-003 CLK  input  1  single clock; all state updates on rising edge.
REQ-004 RST_N  input  1  asynchronous, active-low reset.
REQ-005 REQ  input  N_REQ  per-requester write request, level.
REQ-006 ADDR  input  5*N_REQ  per-requester register/direction address; slice i = [5i+4:5i].
REQ-007 DATA  input  8*N_REQ  per-requester payload; slice i = [8i+7:8i].
REQ-008 CLR_REQ  input  N_REQ  per-requester clear flag.
REQ-009 ACK  output  N_REQ  one-cycle completion pulse to granted requester.
REQ-010 CS  output  1  write strobe to control logic unit.
REQ-011 DATA_OUT  output  16  word to control logic unit.
REQ-012 GNT_ID  output  3  index of current/last granted requester.
REQ-013 BUSY  output  1  high whenever state is not IDLE.

Function
REQ-014 FSM states SHALL be IDLE, ISSUE, WAIT, DONE; no other reachable states.
REQ-015 IDLE: if any REQ bit high, winner chosen round-robin starting at pointer PTR, searching upward with wrap at N_REQ; else stay IDLE.
REQ-016 On grant edge: DATA_OUT <= {CLR_REQ[w], 2'b00, ADDR[w], DATA[w]}, GNT_ID <= w, state -> ISSUE.
REQ-017 ISSUE: CS = 1 for exactly one cycle, then state -> WAIT with counter loaded to WAIT_CYC.
REQ-018 WAIT: CS = 0, counter decrements each cycle; after exactly WAIT_CYC cycles in WAIT, state -> DONE.
REQ-019 DONE: ACK[GNT_ID] = 1 for exactly one cycle, PTR <= (GNT_ID+1) mod N_REQ, state -> IDLE.
REQ-020 DATA_OUT and GNT_ID SHALL hold stable from grant edge until next grant edge.
REQ-021 Timing: REQ sampled in IDLE at cycle 0 -> CS at cycle 1 -> ACK at cycle WAIT_CYC+2; back-to-back CS pulses separated by exactly WAIT_CYC+3 cycles.
REQ-022 REQ/ADDR/DATA/CLR_REQ changes after grant edge SHALL be ignored; transaction completes and ACK still pulses even if REQ drops.
REQ-023 REQ still high in the IDLE cycle following ACK SHALL be treated as a new request (requester must drop REQ on ACK).
REQ-024 Simultaneous requests: exactly one grant per transaction; requester with lowest index at or above PTR (with wrap) wins.
REQ-025 At most one ACK bit high in any cycle; CS and ACK never high in the same cycle.
REQ-026 REQ bits at index >= N_REQ do not exist; GNT_ID upper bits unused are 0.

Reset
REQ-027 RST_N low SHALL immediately force: state IDLE, CS 0, ACK 0, BUSY 0, DATA_OUT 16'h0000, GNT_ID 0, PTR 0, counter 0.
REQ-028 Reset mid-transaction aborts it: no ACK issued for aborted transaction, no CS emitted after reset release until a new grant.
REQ-029 First grant after RST_N release occurs no earlier than the first rising edge with RST_N high.

Verification
REQ-030 Single req: REQ=4'b0001, ADDR0=5'h03, DATA0=8'hA5, CLR_REQ0=0 -> DATA_OUT=16'h03A5, CS high at cycle 1, ACK=4'b0001 at cycle 6 (WAIT_CYC=4).
REQ-031 Clear word: REQ2 with CLR_REQ2=1, ADDR2=5'h1F, DATA2=8'h00 -> DATA_OUT=16'h9F00, GNT_ID=2.
REQ-032 Round-robin: REQ=4'b1111 held, each requester drops on its ACK -> grant order 0,1,2,3, CS pulses 7 cycles apart.
REQ-033 Fairness wrap: PTR=3, REQ=4'b1001 -> requester 3 granted first, then 0.
REQ-034 Abort: assert RST_N low in WAIT -> outputs zero same cycle, no ACK; after release REQ=4'b0010 -> normal grant to 1.
REQ-035 Input glitch: change DATA1 and drop REQ1 during WAIT -> DATA_OUT unchanged, ACK[1] still pulses at cycle 6.
